// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the MCS6530 interval timer.
package mcs6530_pkg;

    localparam int unsigned COUNT_W = 8;
    localparam int unsigned PRESC_W = 10;
    localparam int unsigned ADDR_W  = 4;

    typedef enum logic [1:0] {
        DIV_1    = 2'b00,
        DIV_8    = 2'b01,
        DIV_64   = 2'b10,
        DIV_1024 = 2'b11
    } div_sel_t;

    localparam logic [PRESC_W-1:0] RELOAD_1    = 10'd0;
    localparam logic [PRESC_W-1:0] RELOAD_8    = 10'd7;
    localparam logic [PRESC_W-1:0] RELOAD_64   = 10'd63;
    localparam logic [PRESC_W-1:0] RELOAD_1024 = 10'd1023;

    localparam int unsigned TMR_RD_COUNT = 0;
    localparam int unsigned TMR_RD_FLAG  = 1;
    localparam int unsigned TMR_IE_BIT   = 3;

    // Prescaler reload value (divisor - 1) for a divider selection.
    function automatic logic [PRESC_W-1:0] reload_of(input div_sel_t sel);
        logic [PRESC_W-1:0] r;
        case (sel)
            DIV_1:   r = RELOAD_1;
            DIV_8:   r = RELOAD_8;
            DIV_64:  r = RELOAD_64;
            default: r = RELOAD_1024;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mcs6530_prescaler.sv
// Reloadable 10-bit prescaler producing the timer tick.
module mcs6530_prescaler
    import mcs6530_pkg::*;
(
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] load_sel,
    input  logic [1:0] div_sel,
    input  logic       force_tick,
    output logic       tick_c
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_nxt;

    assign tick_c = (presc == '0) | force_tick;

    // Next prescaler value: a write reloads for the new divider, a tick reloads for the current one.
    always_comb begin
        presc_nxt = presc - PRESC_W'(1);
        if (load) begin
            presc_nxt = reload_of(div_sel_t'(load_sel));
        end else if (tick_c) begin
            presc_nxt = reload_of(div_sel_t'(div_sel));
        end
    end

    // Prescaler register.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            presc <= RELOAD_1024;
        end else begin
            presc <= presc_nxt;
        end
    end

endmodule

// File: rtl/mcs6530_timer.sv
// MCS6530 interval timer: down-counter, interrupt flag and PB7 IRQ drive.
module mcs6530_timer
    import mcs6530_pkg::*;
#(
    parameter int IRQ_ON_PB7 = 1
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       rd_en,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic       irq_en
);

    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_nxt;
    div_sel_t           div_sel;
    div_sel_t           div_sel_nxt;
    logic               ie;
    logic               ie_nxt;
    logic               flag;
    logic               flag_nxt;
    logic               fast;
    logic               fast_nxt;
    logic               tick_c;
    logic               rd_count_c;
    logic               sel_flag_c;
    logic               addr_unused;

    assign addr_unused = addr[2];
    assign sel_flag_c  = (addr[0] == 1'(TMR_RD_FLAG));
    assign rd_count_c  = rd_en & (addr[0] == 1'(TMR_RD_COUNT));

    mcs6530_prescaler u_presc (
        .phi2       (phi2),
        .rst_n      (rst_n),
        .load       (wr_en),
        .load_sel   (addr[1:0]),
        .div_sel    (div_sel),
        .force_tick (fast),
        .tick_c     (tick_c)
    );

    // Next timer state: write wins, an underflow set beats a same-cycle clearing read.
    always_comb begin
        count_nxt   = count;
        div_sel_nxt = div_sel;
        ie_nxt      = ie;
        flag_nxt    = flag;
        fast_nxt    = fast;
        if (wr_en) begin
            count_nxt   = wdata;
            div_sel_nxt = div_sel_t'(addr[1:0]);
            ie_nxt      = addr[TMR_IE_BIT];
            flag_nxt    = 1'b0;
            fast_nxt    = 1'b0;
        end else begin
            if (rd_count_c) begin
                ie_nxt   = addr[TMR_IE_BIT];
                flag_nxt = 1'b0;
            end
            if (tick_c) begin
                count_nxt = count - COUNT_W'(1);
                if (count == '0) begin
                    flag_nxt = 1'b1;
                    fast_nxt = 1'b1;
                end
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge phi2) begin
        if (!rst_n) begin
            count   <= '1;
            div_sel <= DIV_1024;
            ie      <= 1'b0;
            flag    <= 1'b0;
            fast    <= 1'b0;
        end else begin
            count   <= count_nxt;
            div_sel <= div_sel_nxt;
            ie      <= ie_nxt;
            flag    <= flag_nxt;
            fast    <= fast_nxt;
        end
    end

    assign rdata  = sel_flag_c ? {flag, 7'b0} : count;
    assign irq    = ~(flag & ie);
    assign irq_en = 1'(IRQ_ON_PB7 != 0);

endmodule
